rename_ctrl: RTL
================

Name: rename_ctrl

Overview:
- Sequences the rename stage around the RAT: one instruction per cycle, 2 sources, 1 destination.
- Reads source and old-destination aliases from the RAT and allocates a new preg from an internal circular free list.
- Writes the new alias back to the RAT and presents the renamed instruction downstream through a valid/ready pipeline register.
- Returns freed pregs on commit and handles flush by rewinding the free list and pulsing a RAT restore.

Parameters:
- NUM_AREGS, 32, architectural registers (from CORE_PKG).
- NUM_PREGS, 64, physical registers (from CORE_PKG).
- FL_DEPTH, NUM_PREGS-NUM_AREGS, free-list entries.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  controller accepts this cycle.
- in_src1_areg, in_src2_areg, in_dst_areg  in  $clog2(NUM_AREGS) each  instruction aregs.
- in_dst_valid  in  1  instruction writes a destination.
- out_valid  out  1  renamed instruction valid.
- out_ready  in  1  downstream accepts.
- out_src1_preg, out_src2_preg, out_dst_preg, out_old_dst_preg  out  $clog2(NUM_PREGS) each  renamed fields.
- out_dst_valid  out  1  effective dst valid.
- rat_rd_areg [2:0]  out  $clog2(NUM_AREGS)  RAT read addresses: src1, src2, dst.
- rat_rd_preg [2:0]  in  $clog2(NUM_PREGS)  RAT read data (combinational).
- rat_w_en  out  1  RAT write enable.
- rat_w_areg  out  $clog2(NUM_AREGS)  RAT write areg.
- rat_w_preg  out  $clog2(NUM_PREGS)  new alias.
- rat_restore  out  1  RAT copies its committed map.
- commit_valid  in  1  one instruction commits.
- commit_has_dst  in  1  committing instruction had a dst.
- commit_free_preg  in  $clog2(NUM_PREGS)  its old_dst preg, to be freed.
- flush  in  1  squash all uncommitted state.

Behaviour:
- The effective destination is dst_eff = in_dst_valid && in_dst_areg != 0. x0 is never renamed.
- FSM states and transitions:
  - INIT: reset state. An index counter writes preg NUM_AREGS+i into free-list entry i, one entry per cycle. After FL_DEPTH cycles, go to RUN with spec_head = commit_head = 0 and tail = FL_DEPTH (full). Flush and commit are ignored in INIT.
  - RUN: normal operation.
  - RECOVER: entered the cycle after flush. rat_restore=1 for exactly this cycle. Next state is RUN.
- Free-list pointers are $clog2(FL_DEPTH)+1 bits and wrap naturally.
  - count = tail - spec_head.
  - empty when count == 0.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready) && (!dst_eff || count != 0).
- Accept occurs when in_valid && in_ready. In that same cycle:
  - rat_rd_areg = {dst, src2, src1} are always driven from the inputs.
  - The output register loads rat_rd_preg[0], [1], [2] as the src1, src2 and old-dst pregs.
  - If dst_eff: out_dst_preg = fl[spec_head], spec_head++, rat_w_en=1, rat_w_areg=in_dst_areg, rat_w_preg=fl[spec_head].
  - If not dst_eff: out_dst_preg=0 and out_old_dst_preg=0.
- The RAT write takes effect at the clock edge. The next instruction's combinational read therefore sees it, so no bypass is needed.
- Latency is 1 cycle from accept to out_valid. out_valid clears when out_ready is high and no new accept occurs.
- Commit with commit_has_dst:
  - fl[tail] = commit_free_preg, tail++, commit_head++.
  - Commit and alloc in the same cycle are both applied.
  - A push when count == FL_DEPTH is illegal. Cover it with an assertion only.
- Flush (RUN):
  - spec_head <= commit_head, including the same-cycle commit increment.
  - out_valid <= 0 and no accept.
  - The same-cycle commit push is still applied.
  - Next state is RECOVER.
- Flush in RECOVER restarts RECOVER for one more cycle.
- Reset values:
  - in_ready, out_valid, rat_w_en, rat_restore all 0.
  - All out_* fields 0.
  - state=INIT, pointers 0.
- rst asserted mid-operation discards all state and re-runs INIT.

Decomposition:
- CORE_PKG holds NUM_AREGS, NUM_PREGS, areg_t/preg_t typedefs and a renamed_inst_t struct for the output register.
- One sub-module, rename_freelist: circular buffer with spec_head, commit_head, tail, count, alloc/push/rewind ports and the INIT fill counter.

Test Plan:
- Reset release: after exactly 32 cycles of INIT, in_ready=1; first accept of dst=5 yields out_dst_preg=32 and rat_w_preg=32.
- Back-to-back dependency: inst A dst x5, next cycle inst B src1 x5 -> B out_src1_preg=32, B out_old_dst_preg irrelevant; B dst x5 -> out_old_dst_preg=32, out_dst_preg=33.
- Exhaustion: 32 dst-writing instructions with no commit, then in_ready=0 with count=0; a commit freeing preg 7 -> next cycle accept, out_dst_preg=7.
- x0 and no-dst: dst_areg=0 with in_dst_valid=1 -> rat_w_en=0, spec_head unchanged, out_dst_valid=0.
- Flush: after 3 allocs and 1 commit, flush -> spec_head=1, out_valid=0, rat_restore=1 for one cycle, in_ready=0 for 2 cycles, next alloc returns preg 33.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, outputs held stable, no RAT write; out_ready=1 resumes with no loss or duplication.

Source files
------------

// File: rtl/rename_ctrl_pkg.sv
// Shared sizes, types and helpers for the rename controller and its free list.
package rename_ctrl_pkg;

  localparam int unsigned NUM_AREGS = 32;
  localparam int unsigned NUM_PREGS = 64;
  localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int unsigned AREG_W    = $clog2(NUM_AREGS);
  localparam int unsigned PREG_W    = $clog2(NUM_PREGS);
  localparam int unsigned FL_PTR_W  = $clog2(FL_DEPTH) + 1;

  typedef logic [AREG_W-1:0]   areg_t;
  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef enum logic [1:0] {StInit, StRun, StRecover} state_e;

  typedef struct packed {
    preg_t src1;
    preg_t src2;
    preg_t dst;
    preg_t old_dst;
    logic  dst_valid;
  } renamed_inst_t;

  // x0 is hardwired, so it never gets a new alias.
  function automatic logic is_dst_eff(input logic dst_valid, input areg_t dst_areg);
    return dst_valid && (dst_areg != '0);
  endfunction

endpackage

// File: rtl/rename_ctrl_if.sv
// Rename-stage bundle: upstream/downstream handshakes, RAT access, commit and flush.
interface rename_ctrl_if;
  import rename_ctrl_pkg::*;

  logic        in_valid;
  logic        in_ready;
  areg_t       in_src1_areg;
  areg_t       in_src2_areg;
  areg_t       in_dst_areg;
  logic        in_dst_valid;

  logic        out_valid;
  logic        out_ready;
  preg_t       out_src1_preg;
  preg_t       out_src2_preg;
  preg_t       out_dst_preg;
  preg_t       out_old_dst_preg;
  logic        out_dst_valid;

  areg_t [2:0] rat_rd_areg;
  preg_t [2:0] rat_rd_preg;
  logic        rat_w_en;
  areg_t       rat_w_areg;
  preg_t       rat_w_preg;
  logic        rat_restore;

  logic        commit_valid;
  logic        commit_has_dst;
  preg_t       commit_free_preg;
  logic        flush;

  modport master (
    output in_valid, in_src1_areg, in_src2_areg, in_dst_areg, in_dst_valid, out_ready,
    output rat_rd_preg, commit_valid, commit_has_dst, commit_free_preg, flush,
    input  in_ready, out_valid, out_src1_preg, out_src2_preg, out_dst_preg, out_old_dst_preg,
    input  out_dst_valid, rat_rd_areg, rat_w_en, rat_w_areg, rat_w_preg, rat_restore
  );

  modport slave (
    input  in_valid, in_src1_areg, in_src2_areg, in_dst_areg, in_dst_valid, out_ready,
    input  rat_rd_preg, commit_valid, commit_has_dst, commit_free_preg, flush,
    output in_ready, out_valid, out_src1_preg, out_src2_preg, out_dst_preg, out_old_dst_preg,
    output out_dst_valid, rat_rd_areg, rat_w_en, rat_w_areg, rat_w_preg, rat_restore
  );

endinterface

// File: rtl/rename_freelist.sv
// Circular free list of pregs: speculative head for allocation, commit head for
// flush rewind, tail for frees. Self-fills with NUM_AREGS..NUM_PREGS-1 out of reset.
module rename_freelist
  import rename_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    alloc_i,
  input  logic    push_i,
  input  preg_t   push_preg_i,
  input  logic    rewind_i,
  output logic    fill_last_o,
  output preg_t   head_preg_o,
  output fl_ptr_t count_o
);

  localparam int unsigned IdxW   = FL_PTR_W - 1;
  localparam fl_ptr_t     PtrOne = fl_ptr_t'(1);

  preg_t           fl_q [FL_DEPTH];
  logic            fill_q;
  fl_ptr_t         spec_head_q, commit_head_q, tail_q;
  logic            wr_en;
  preg_t           wr_data;
  logic [IdxW-1:0] tail_idx, head_idx;

  assign tail_idx    = tail_q[IdxW-1:0];
  assign head_idx    = spec_head_q[IdxW-1:0];
  assign fill_last_o = fill_q && (tail_q == fl_ptr_t'(FL_DEPTH - 1));
  assign head_preg_o = fl_q[head_idx];
  assign count_o     = tail_q - spec_head_q;
  assign wr_en       = fill_q || push_i;
  assign wr_data     = fill_q ? preg_t'(NUM_AREGS) + preg_t'(tail_q) : push_preg_i;

  always_ff @(posedge clk) begin
    if (wr_en) fl_q[tail_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q        <= 1'b1;
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
    end else if (fill_q) begin
      tail_q <= tail_q + PtrOne;
      if (fill_last_o) fill_q <= 1'b0;
    end else begin
      if (push_i) begin
        tail_q        <= tail_q + PtrOne;
        commit_head_q <= commit_head_q + PtrOne;
      end
      // Rewind includes a commit landing in the same cycle.
      if (rewind_i)     spec_head_q <= commit_head_q + fl_ptr_t'(push_i);
      else if (alloc_i) spec_head_q <= spec_head_q + PtrOne;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(push_i && !fill_q && (count_o == fl_ptr_t'(FL_DEPTH))));

endmodule

// File: rtl/rename_ctrl.sv
// Rename stage: reads RAT aliases, allocates a new preg, writes it back, and
// registers the renamed instruction behind a valid/ready handshake.
module rename_ctrl
  import rename_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst,
  rename_ctrl_if.slave bus
);

  state_e        state_q;
  renamed_inst_t out_q, out_d;
  logic          out_valid_q, rat_restore_q;
  logic          dst_eff, accept, alloc, push, rewind, fill_last;
  preg_t         head_preg;
  fl_ptr_t       fl_count;

  assign dst_eff = is_dst_eff(bus.in_dst_valid, bus.in_dst_areg);
  assign bus.in_ready = (state_q == StRun) && !bus.flush && (!out_valid_q || bus.out_ready) &&
                        (!dst_eff || (fl_count != '0));
  assign accept = bus.in_valid && bus.in_ready;
  assign alloc  = accept && dst_eff;
  assign push   = (state_q != StInit) && bus.commit_valid && bus.commit_has_dst;
  assign rewind = (state_q != StInit) && bus.flush;

  assign bus.rat_rd_areg = {bus.in_dst_areg, bus.in_src2_areg, bus.in_src1_areg};
  assign bus.rat_w_en    = alloc;
  assign bus.rat_w_areg  = bus.in_dst_areg;
  assign bus.rat_w_preg  = head_preg;
  assign bus.rat_restore = rat_restore_q;

  assign bus.out_valid        = out_valid_q;
  assign bus.out_src1_preg    = out_q.src1;
  assign bus.out_src2_preg    = out_q.src2;
  assign bus.out_dst_preg     = out_q.dst;
  assign bus.out_old_dst_preg = out_q.old_dst;
  assign bus.out_dst_valid    = out_q.dst_valid;

  always_comb begin
    out_d      = '0;
    out_d.src1 = bus.rat_rd_preg[0];
    out_d.src2 = bus.rat_rd_preg[1];
    if (dst_eff) begin
      out_d.dst       = head_preg;
      out_d.old_dst   = bus.rat_rd_preg[2];
      out_d.dst_valid = 1'b1;
    end
  end

  rename_freelist u_freelist (
    .clk        (clk),
    .rst        (rst),
    .alloc_i    (alloc),
    .push_i     (push),
    .push_preg_i(bus.commit_free_preg),
    .rewind_i   (rewind),
    .fill_last_o(fill_last),
    .head_preg_o(head_preg),
    .count_o    (fl_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StInit;
      out_valid_q   <= 1'b0;
      out_q         <= '0;
      rat_restore_q <= 1'b0;
    end else begin
      rat_restore_q <= 1'b0;
      case (state_q)
        StInit: if (fill_last) state_q <= StRun;
        StRun, StRecover: begin
          if (bus.flush) begin
            state_q       <= StRecover;
            rat_restore_q <= 1'b1;
          end else begin
            state_q <= StRun;
          end
        end
        default: state_q <= StInit;
      endcase
      if (rewind) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_q       <= out_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
